// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle restoring divider sequencer for the EX stage.
// Executes DIV (signed) / DIVU (unsigned) one quotient bit per cycle and
// returns {remainder, quotient} for the HI/LO write path.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   signed_div_i  1 = DIV (two's complement), 0 = DIVU
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       division request, held by EX until ready_o
//   annul_i       cancel request (flush/exception in EX)
//   result_o      {remainder, quotient}, registered
//   ready_o       result valid, registered
//   stallreq_o    combinational pipeline stall request
module div_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [DATA_W-1:0]   dvd, dvd_nxt;   // dividend magnitude, shifted out MSB first
  logic [DATA_W-1:0]   dvs, dvs_nxt;   // divisor magnitude
  logic [DATA_W-1:0]   rem, rem_nxt;   // partial remainder
  logic [DATA_W-1:0]   quo, quo_nxt;   // quotient bits collected so far
  logic                neg_q, neg_q_nxt;
  logic                neg_r, neg_r_nxt;
  logic [2*DATA_W-1:0] result_nxt;
  logic                ready_nxt;

  // One restoring step: shift in next dividend bit, trial-subtract divisor.
  // The compare is done at DATA_W+1 bits so the shifted-out carry counts;
  // when it succeeds the true difference is below the divisor, so the
  // low DATA_W bits of the subtraction are exact.
  logic [DATA_W:0]   partial;
  logic              trial_ge;
  logic [DATA_W-1:0] trial_diff;

  assign partial    = {rem, dvd[DATA_W-1]};
  assign trial_ge   = partial >= {1'b0, dvs};
  assign trial_diff = partial[DATA_W-1:0] - dvs;

  // Stall EX while a request is outstanding and not yet answered.
  assign stallreq_o = rst ? 1'b0 : (start_i & ~ready_o & ~annul_i);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FREE;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      quo      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dvd      <= dvd_nxt;
      dvs      <= dvs_nxt;
      rem      <= rem_nxt;
      quo      <= quo_nxt;
      neg_q    <= neg_q_nxt;
      neg_r    <= neg_r_nxt;
      result_o <= result_nxt;
      ready_o  <= ready_nxt;
    end
  end

  // Next-state and datapath/output update.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dvd_nxt    = dvd;
    dvs_nxt    = dvs;
    rem_nxt    = rem;
    quo_nxt    = quo;
    neg_q_nxt  = neg_q;
    neg_r_nxt  = neg_r;
    result_nxt = result_o;
    ready_nxt  = ready_o;

    case (state)
      ST_FREE: begin
        result_nxt = '0;
        ready_nxt  = 1'b0;
        if (start_i && !annul_i) begin
          // Signed mode works on magnitudes; 0x80.. maps to itself, which
          // is the correct unsigned magnitude.
          dvd_nxt   = (signed_div_i && opdata1_i[DATA_W-1]) ? DATA_W'(-opdata1_i) : opdata1_i;
          dvs_nxt   = (signed_div_i && opdata2_i[DATA_W-1]) ? DATA_W'(-opdata2_i) : opdata2_i;
          neg_q_nxt = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_r_nxt = signed_div_i & opdata1_i[DATA_W-1];
          rem_nxt   = '0;
          quo_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
        end
      end

      ST_BYZERO: begin
        // cnt gives the divide-by-zero path its two-edge latency.
        if (cnt == '0) begin
          cnt_nxt = CNT_W'(1);
        end else begin
          cnt_nxt    = '0;
          result_nxt = '0;
          ready_nxt  = 1'b1;
          state_nxt  = ST_END;
        end
      end

      ST_ON: begin
        if (annul_i) begin
          result_nxt = '0;
          ready_nxt  = 1'b0;
          cnt_nxt    = '0;
          state_nxt  = ST_FREE;
        end else if (cnt != CNT_W'(DATA_W)) begin
          dvd_nxt = {dvd[DATA_W-2:0], 1'b0};
          rem_nxt = trial_ge ? trial_diff : partial[DATA_W-1:0];
          quo_nxt = {quo[DATA_W-2:0], trial_ge};
          cnt_nxt = cnt + CNT_W'(1);
        end else begin
          // Sign correction; negating zero yields zero.
          result_nxt = {(neg_r ? DATA_W'(-rem) : rem), (neg_q ? DATA_W'(-quo) : quo)};
          ready_nxt  = 1'b1;
          cnt_nxt    = '0;
          state_nxt  = ST_END;
        end
      end

      ST_END: begin
        if (!start_i) begin
          result_nxt = '0;
          ready_nxt  = 1'b0;
          state_nxt  = ST_FREE;
        end
      end

      default: begin
        state_nxt = ST_FREE;
      end
    endcase
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle divide sequencer beside the EX-stage ALU; executes DIV/DIVU one quotient bit per cycle (restoring algorithm).
- Stalls the pipeline while busy.
- Returns a 64-bit {remainder, quotient} result that EX forwards onto its HI/LO write path (hi_out = remainder, lo_out = quotient, hilo_en_out asserted).
- One division in flight; EX holds the request until ready_o.

Parameters:
- DATA_W, 32, operand/quotient/remainder width. The bench exercises only 32.
- CNT_W, 6, iteration counter width. Must hold the value DATA_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high (RstEnable = 1'b1).
- signed_div_i  input  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  input  DATA_W  dividend.
- opdata2_i  input  DATA_W  divisor.
- start_i  input  1  EX requests a division. Held high until ready_o is seen.
- annul_i  input  1  cancel: flush/exception in EX.
- result_o  output  2*DATA_W  {remainder[63:32], quotient[31:0]}; registered.
- ready_o  output  1  result valid; registered.
- stallreq_o  output  1  combinational pipeline stall request.

Behaviour:
- Reset is checked first at every edge. On reset: state=FREE, cnt=0, result_o=0, ready_o=0, internal dividend/divisor registers=0. Reset mid-operation aborts the division with no residue.
- States: FREE, BYZERO, ON, END.

FREE:
- Accept when start_i=1 and annul_i=0; otherwise stay, with result_o=0 and ready_o=0.
- On accept, latch the operands. Later changes on opdata*_i are ignored until the next accept.
- Signed mode: latch |opdata1| and |opdata2|. Record neg_q = sign1^sign2 and neg_r = sign1.
- Unsigned mode: latch operands raw; neg_q = neg_r = 0.
- Divisor == 0: go to BYZERO. Otherwise go to ON with cnt=0.

BYZERO:
- Next edge: result_o=0, ready_o=1, go to END. Divide-by-zero result is defined as 0.

ON:
- If annul_i=1: go to FREE; result_o=0, ready_o=0; no result produced.
- Else, while cnt<DATA_W, each edge:
  - Shift the partial remainder left 1, bringing in the next dividend MSB.
  - Trial-subtract the divisor as a (DATA_W+1)-bit subtract.
  - If non-negative: keep the difference and shift quotient bit 1. Else: restore and shift 0.
  - cnt++.
- When cnt==DATA_W, next edge:
  - Quotient is negated if neg_q; remainder is negated if neg_r.
  - result_o={rem, quo}, ready_o=1, go to END.

END:
- Hold result_o and ready_o=1 while start_i=1.
- When start_i=0: go to FREE; result_o=0, ready_o=0.
- annul_i in END is ignored; EX drops start_i itself.

Latency:
- Accept edge = E0. Nonzero divisor: ready_o high after edge E0+33 (32 iterations + 1 correction edge).
- Divisor zero: ready_o high after edge E0+2.

stallreq_o:
- stallreq_o = start_i & ~ready_o & ~annul_i, combinational, valid in the same cycle start_i rises.
- Forced 0 while rst=1.

Arithmetic and sign cases:
- Absolute value of 0x80000000 is 0x80000000 treated as unsigned (correct magnitude).
- Signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000 (two's-complement wrap), remainder 0.
- Remainder magnitude is always less than the divisor magnitude. Remainder sign follows the dividend; a zero result is never negated to a nonzero value.

Other boundaries:
- start_i asserted with annul_i in the same cycle in FREE: not accepted.
- New start_i in the cycle right after return to FREE: accepted normally (back-to-back divisions allowed).
- Only one divide is in flight; start_i pulses while busy have no effect.

Test Plan:
1. DIVU 100 / 7, start held → stallreq_o=1 from cycle 0; after edge E0+33: result_o=0x00000002_0000000E, ready_o=1, stallreq_o=0. Drop start → next edge ready_o=0, result_o=0.
2. DIV -7 (0xFFFFFFF9) / 2 → result_o=0xFFFFFFFF_FFFFFFFD (rem -1, quo -3). DIV 7 / -2 → 0x00000001_FFFFFFFD.
3. DIV 0x80000000 / 0xFFFFFFFF → result_o=0x00000000_80000000. DIVU 0xFFFFFFFF / 1 → 0x00000000_FFFFFFFF. DIVU 5 / 9 → 0x00000005_00000000.
4. DIVU 1234 / 0 → ready_o=1 after edge E0+2, result_o=0, stallreq_o falls in the same cycle.
5. DIVU 1000 / 3, annul_i pulsed at iteration 10 → FREE next edge; ready_o never rises; result_o=0. A new DIVU 9 / 3 started the following cycle yields 0x00000000_00000003 at its own E0+33.
6. Reset at iteration 20 → next edge state FREE, ready_o=0, result_o=0. Operands changed during ON do not affect the result. Holding start_i 5 extra cycles in END keeps ready_o and result_o stable.
